// File: rtl/wbarb_pkg.sv
// Shared types and the rotate-priority pick used by the Wishbone round-robin arbiters.
package wbarb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  localparam int unsigned RR_MAX_M = 32;
  localparam int unsigned RR_IW    = $clog2(RR_MAX_M);

  typedef logic [RR_MAX_M-1:0] rr_vec_t;

  // First requester after 'last', wrapping explicitly at n (n need not be a power of two, n <= RR_MAX_M).
  function automatic rr_vec_t rr_pick_onehot(input rr_vec_t req, input int unsigned last,
                                             input int unsigned n);
    rr_vec_t     gnt;
    int unsigned idx;
    logic        found;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= RR_MAX_M; k++) begin
      idx = last + k;
      if (idx >= n) idx = idx - n;
      if (k <= n && !found && idx < RR_MAX_M && req[idx[RR_IW-1:0]]) begin
        gnt[idx[RR_IW-1:0]] = 1'b1;
        found               = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/wbarb_rr_pick.sv
// Combinational round-robin picker: requests plus last-owner pointer -> one-hot grant and its index.
module wbarb_rr_pick
  import wbarb_pkg::*;
#(
  parameter int NM = 2,
  parameter int IW = $clog2(NM)
) (
  input  logic [NM-1:0] req,
  input  logic [IW-1:0] last_ptr,
  output logic [NM-1:0] gnt,
  output logic [IW-1:0] gnt_idx
);

  always_comb begin
    gnt     = NM'(rr_pick_onehot(rr_vec_t'(req), 32'(last_ptr), NM));
    gnt_idx = '0;
    for (int i = 0; i < NM; i++)
      if (gnt[i]) gnt_idx = IW'(i);
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone classic arbiter: NM masters share one slave, grant locked for the owner's CYC.
// Optional stalled-slave bus error generation with `define WBARB_TIMEOUT_EN.
module wb_rr_arbiter
  import wbarb_pkg::*;
#(
  parameter int NM      = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_reset_ni,
  input  logic [NM-1:0]        m_cyc_i,
  input  logic [NM-1:0]        m_stb_i,
  input  logic [NM-1:0]        m_we_i,
  input  logic [NM*AW-1:0]     m_adr_i,
  input  logic [NM*DW-1:0]     m_dat_i,
  input  logic [NM*DW/8-1:0]   m_sel_i,
  output logic [NM-1:0]        m_ack_o,
  output logic [NM-1:0]        m_err_o,
  output logic [DW-1:0]        m_dat_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  output logic                 s_we_o,
  output logic [AW-1:0]        s_adr_o,
  output logic [DW-1:0]        s_dat_o,
  output logic [DW/8-1:0]      s_sel_o,
  input  logic                 s_ack_i,
  input  logic                 s_err_i,
  input  logic [DW-1:0]        s_dat_i,
  output logic [NM-1:0]        grant_o
);

  localparam int IW = $clog2(NM);
  localparam int SW = DW / 8;

  arb_state_t    state;
  logic [IW-1:0] own;
  logic [IW-1:0] last_ptr;
  logic [NM-1:0] pick_gnt;
  logic [IW-1:0] pick_idx;
  logic          granted;
  logic          own_cyc;
  logic          stb_raw;
  logic          to_fire;

  wbarb_rr_pick #(.NM(NM), .IW(IW)) u_pick (
    .req      (m_cyc_i),
    .last_ptr (last_ptr),
    .gnt      (pick_gnt),
    .gnt_idx  (pick_idx)
  );

  // last_ptr resets to NM-1 so master 0 wins the first arbitration.
  always_ff @(posedge wb_clk_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) begin
      state    <= ARB_IDLE;
      own      <= '0;
      last_ptr <= IW'(NM - 1);
    end else begin
      case (state)
        ARB_IDLE: if (|pick_gnt) begin
          state <= ARB_GRANT;
          own   <= pick_idx;
        end
        ARB_GRANT: if (!own_cyc) begin
          state    <= ARB_IDLE;
          last_ptr <= own;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign granted = (state == ARB_GRANT);
  assign own_cyc = m_cyc_i[own];
  assign s_cyc_o = granted && own_cyc;
  assign stb_raw = s_cyc_o && m_stb_i[own];
  assign s_stb_o = stb_raw && !to_fire;

  always_comb begin
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    grant_o = '0;
    if (granted) begin
      s_we_o       = m_we_i[own];
      s_adr_o      = m_adr_i[own*AW +: AW];
      s_dat_o      = m_dat_i[own*DW +: DW];
      s_sel_o      = m_sel_i[own*SW +: SW];
      grant_o[own] = 1'b1;
    end
  end

  // Responses only count while a strobe is presented; stray ack/err are dropped.
  assign m_ack_o = (s_ack_i && s_stb_o) ? grant_o : '0;
  assign m_err_o = ((s_err_i && s_stb_o) || to_fire) ? grant_o : '0;
  assign m_dat_o = s_dat_i;

`ifdef WBARB_TIMEOUT_EN
  localparam int              CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   TO_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] to_cnt;

  // Fires on the TIMEOUT-th unanswered strobe cycle; that cycle's strobe is withheld from the slave.
  assign to_fire = stb_raw && (to_cnt == TO_LAST);

  always_ff @(posedge wb_clk_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni)
      to_cnt <= '0;
    else if (!s_cyc_o || to_fire || (stb_raw && (s_ack_i || s_err_i)))
      to_cnt <= '0;
    else if (stb_raw)
      to_cnt <= to_cnt + 1'b1;
  end
`else
  assign to_fire = 1'b0;
`endif

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Scoreboarded bench for wb_rr_arbiter: reset, read, fairness, bus lock, ack/err, timeout, async reset.
module tb_wb_rr_arbiter;
  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NM-1:0]     m_cyc = '0, m_stb = '0, m_we = '0;
  logic [NM*AW-1:0]  m_adr = '0;
  logic [NM*DW-1:0]  m_dat = '0;
  logic [NM*SW-1:0]  m_sel = '1;
  logic [NM-1:0]     m_ack_o, m_err_o, grant_o;
  logic [DW-1:0]     m_dat_o, s_dat_o;
  logic              s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]     s_adr_o;
  logic [SW-1:0]     s_sel_o;
  logic              s_ack = 1'b0, s_err = 1'b0;
  logic [DW-1:0]     s_dat = '0;

  typedef struct {
    logic [NM-1:0] ack;
    logic [NM-1:0] err;
    logic [DW-1:0] dat;
    bit            chk_dat;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  wb_rr_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_reset_ni(rst_n),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_dat_i(s_dat),
    .grant_o(grant_o)
  );

  task automatic drv(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); endtask

  task automatic wait_resp(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (|m_ack_o || |m_err_o) begin seen = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; m_cyc = 2'b11; m_stb = 2'b11; s_ack = 1'b1; s_err = 1'b1;
    drv(); drv(); smp();
    n_cmp++; if (grant_o !== 2'b00) begin n_bad++; $display("FAIL rst_grant: got %b want 00", grant_o); end
    n_cmp++; if (s_cyc_o !== 1'b0) begin n_bad++; $display("FAIL rst_scyc: got %b want 0", s_cyc_o); end
    n_cmp++; if (s_stb_o !== 1'b0) begin n_bad++; $display("FAIL rst_sstb: got %b want 0", s_stb_o); end
    n_cmp++; if (m_ack_o !== 2'b00) begin n_bad++; $display("FAIL rst_ack: got %b want 00", m_ack_o); end
    n_cmp++; if (m_err_o !== 2'b00) begin n_bad++; $display("FAIL rst_err: got %b want 00", m_err_o); end
    drv(); m_cyc = '0; m_stb = '0; s_ack = 1'b0; s_err = 1'b0; rst_n = 1'b1;
    drv();
  endtask

  task automatic test_single_read();
    bit seen;
    drv();
    m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b00; m_adr[0 +: AW] = 32'h1000_0004;
    exp_q.push_back('{ack: 2'b01, err: 2'b00, dat: 32'hDEAD_BEEF, chk_dat: 1'b1});
    smp();
    n_cmp++; if (grant_o !== 2'b00) begin n_bad++; $display("FAIL rd_latency: got %b want 00", grant_o); end
    drv(); smp();
    n_cmp++; if (grant_o !== 2'b01) begin n_bad++; $display("FAIL rd_grant: got %b want 01", grant_o); end
    n_cmp++; if (s_adr_o !== 32'h1000_0004) begin n_bad++; $display("FAIL rd_adr: got %h want 10000004", s_adr_o); end
    n_cmp++; if (s_stb_o !== 1'b1) begin n_bad++; $display("FAIL rd_stb: got %b want 1", s_stb_o); end
    drv(); drv(); s_ack = 1'b1; s_dat = 32'hDEAD_BEEF;
    wait_resp(seen);
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL rd_resp_timeout: got none want ack"); end
    if (seen && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++; if (m_ack_o !== e.ack) begin n_bad++; $display("FAIL rd_ack: got %b want %b", m_ack_o, e.ack); end
      n_cmp++; if (m_dat_o !== e.dat) begin n_bad++; $display("FAIL rd_dat: got %h want %h", m_dat_o, e.dat); end
    end
    drv(); s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    smp();
    n_cmp++; if (s_cyc_o !== 1'b0) begin n_bad++; $display("FAIL rd_release: got %b want 0", s_cyc_o); end
    drv(); smp();
    n_cmp++; if (grant_o !== 2'b00) begin n_bad++; $display("FAIL rd_idle: got %b want 00", grant_o); end
  endtask

  task automatic test_fairness();
    rst_n = 1'b0; drv(); rst_n = 1'b1; drv();
    m_cyc = 2'b11; m_stb = 2'b11; m_adr[0 +: AW] = 32'hA000_0000; m_adr[AW +: AW] = 32'hA111_1111;
    drv(); smp();
    n_cmp++; if (grant_o !== 2'b01) begin n_bad++; $display("FAIL fair_first: got %b want 01", grant_o); end
    n_cmp++; if (s_adr_o !== 32'hA000_0000) begin n_bad++; $display("FAIL fair_adr0: got %h want a0000000", s_adr_o); end
    drv(); m_cyc = 2'b10; m_stb = 2'b10;
    drv(); smp();
    n_cmp++; if (grant_o !== 2'b00) begin n_bad++; $display("FAIL fair_gap: got %b want 00", grant_o); end
    drv(); smp();
    n_cmp++; if (grant_o !== 2'b10) begin n_bad++; $display("FAIL fair_second: got %b want 10", grant_o); end
    n_cmp++; if (s_adr_o !== 32'hA111_1111) begin n_bad++; $display("FAIL fair_adr1: got %h want a1111111", s_adr_o); end
    drv(); m_cyc = 2'b00; m_stb = 2'b00;
    drv(); m_cyc = 2'b11; m_stb = 2'b11;
    drv(); smp();
    n_cmp++; if (grant_o !== 2'b01) begin n_bad++; $display("FAIL fair_rotate: got %b want 01", grant_o); end
    drv(); m_cyc = 2'b10; m_stb = 2'b10;
    drv(); m_cyc = 2'b11; m_stb = 2'b11;
    drv(); smp();
    n_cmp++; if (grant_o !== 2'b10) begin n_bad++; $display("FAIL fair_rereq: got %b want 10", grant_o); end
    drv(); m_cyc = '0; m_stb = '0;
    drv(); drv();
  endtask

  task automatic test_lock();
    logic [DW-1:0] wd;
    m_cyc = 2'b10; m_stb = 2'b10; m_we = 2'b10; m_adr[AW +: AW] = 32'h2000_0040;
    drv();
    for (int k = 0; k < 3; k++) begin
      wd = 32'h5A5A_0000 + DW'(k);
      m_cyc = 2'b11; m_stb = 2'b11; m_dat[DW +: DW] = wd; s_ack = 1'b1;
      exp_q.push_back('{ack: 2'b10, err: 2'b00, dat: '0, chk_dat: 1'b0});
      smp();
      n_cmp++; if (grant_o !== 2'b10) begin n_bad++; $display("FAIL lock_grant[%0d]: got %b want 10", k, grant_o); end
      n_cmp++; if (s_dat_o !== wd || s_we_o !== 1'b1) begin n_bad++; $display("FAIL lock_wr[%0d]: got %h/%b want %h/1", k, s_dat_o, s_we_o, wd); end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++; if (m_ack_o !== e.ack) begin n_bad++; $display("FAIL lock_ack[%0d]: got %b want %b", k, m_ack_o, e.ack); end
      end
      drv(); m_stb = 2'b01;
      smp();
      n_cmp++; if (m_ack_o !== 2'b00 || grant_o !== 2'b10) begin n_bad++; $display("FAIL lock_gap[%0d]: got ack %b grant %b want 00/10", k, m_ack_o, grant_o); end
      drv();
    end
    s_ack = 1'b0; m_cyc = 2'b01; m_stb = 2'b01; m_we = '0; m_dat[0 +: DW] = 32'h0;
    smp();
    n_cmp++; if (s_cyc_o !== 1'b0) begin n_bad++; $display("FAIL lock_drop: got %b want 0", s_cyc_o); end
    drv(); drv(); smp();
    n_cmp++; if (grant_o !== 2'b01) begin n_bad++; $display("FAIL lock_next: got %b want 01", grant_o); end
    drv(); s_ack = 1'b1; s_err = 1'b1; s_dat = 32'hC0FF_EE00;
    exp_q.push_back('{ack: 2'b01, err: 2'b01, dat: 32'hC0FF_EE00, chk_dat: 1'b1});
    smp();
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++; if (m_ack_o !== e.ack || m_err_o !== e.err) begin n_bad++; $display("FAIL ackerr: got %b/%b want %b/%b", m_ack_o, m_err_o, e.ack, e.err); end
      n_cmp++; if (e.chk_dat && m_dat_o !== e.dat) begin n_bad++; $display("FAIL ackerr_dat: got %h want %h", m_dat_o, e.dat); end
    end
    drv(); s_ack = 1'b0; s_err = 1'b0; m_cyc = '0; m_stb = '0;
    drv(); drv();
  endtask

  task automatic test_timeout();
    int first_err = 0;
    int n_err = 0;
    logic stb_at_err = 1'b1;
`ifdef WBARB_TIMEOUT_EN
    localparam int WIN = 12;
    exp_q.push_back('{ack: 2'b00, err: 2'b01, dat: '0, chk_dat: 1'b0});
`else
    localparam int WIN = 100;
`endif
    m_cyc = 2'b01; m_stb = 2'b01;
    drv();
    for (int c = 1; c <= WIN; c++) begin
      smp();
      if (|m_err_o) begin
        n_err++;
        if (first_err == 0) begin first_err = c; stb_at_err = s_stb_o; end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_cmp++; if (m_err_o !== e.err || m_ack_o !== e.ack) begin n_bad++; $display("FAIL to_resp: got %b/%b want %b/%b", m_err_o, m_ack_o, e.err, e.ack); end
        end
      end
      drv();
    end
    smp();
    n_cmp++; if (grant_o !== 2'b01) begin n_bad++; $display("FAIL to_grant_kept: got %b want 01", grant_o); end
`ifdef WBARB_TIMEOUT_EN
    n_cmp++; if (first_err != TO) begin n_bad++; $display("FAIL to_cycle: got %0d want %0d", first_err, TO); end
    n_cmp++; if (n_err != 1) begin n_bad++; $display("FAIL to_pulses: got %0d want 1", n_err); end
    n_cmp++; if (stb_at_err !== 1'b0) begin n_bad++; $display("FAIL to_stb_forced: got %b want 0", stb_at_err); end
`else
    n_cmp++; if (n_err != 0) begin n_bad++; $display("FAIL to_none: got %0d errs (first at %0d, stb %b) want 0", n_err, first_err, stb_at_err); end
    n_cmp++; if (s_stb_o !== 1'b1) begin n_bad++; $display("FAIL to_wait: got stb %b want 1", s_stb_o); end
`endif
    drv(); m_cyc = '0; m_stb = '0;
    drv(); drv();
  endtask

  task automatic test_reset_mid();
    m_cyc = 2'b01; m_stb = 2'b01;
    drv(); smp();
    n_cmp++; if (s_cyc_o !== 1'b1) begin n_bad++; $display("FAIL rm_before: got %b want 1", s_cyc_o); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin n_bad++; $display("FAIL rm_async: got cyc %b stb %b want 0/0", s_cyc_o, s_stb_o); end
    n_cmp++; if (grant_o !== 2'b00) begin n_bad++; $display("FAIL rm_grant: got %b want 00", grant_o); end
    drv(); rst_n = 1'b1; m_cyc = 2'b11; m_stb = 2'b11;
    drv(); smp();
    n_cmp++; if (grant_o !== 2'b01) begin n_bad++; $display("FAIL rm_first: got %b want 01", grant_o); end
    drv(); m_cyc = '0; m_stb = '0;
    drv(); drv();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_fairness();
    test_lock();
    test_timeout();
    test_reset_mid();
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL sb_drain: got %0d pending want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish by 100000ns");
    $fatal(1, "watchdog");
  end

endmodule
